// File: rtl/cpu_rp2a03_apu_frame_counter_if.sv
// Bus between the APU frame sequencer and its host: CPU-cycle strobe,
// $4017 write, $4015 read, and the quarter/half/IRQ outputs.
interface cpu_rp2a03_apu_frame_counter_if;
    logic       cpu_cycle_i;
    logic       frame_counter_reg_wr_i;
    logic [7:0] frame_counter_wr_data_i;
    logic       status_reg_rd_i;
    logic       quarter_frame_o;
    logic       half_frame_o;
    logic       frame_irq_o;

    modport master (
        output cpu_cycle_i,
        output frame_counter_reg_wr_i,
        output frame_counter_wr_data_i,
        output status_reg_rd_i,
        input  quarter_frame_o,
        input  half_frame_o,
        input  frame_irq_o
    );

    modport slave (
        input  cpu_cycle_i,
        input  frame_counter_reg_wr_i,
        input  frame_counter_wr_data_i,
        input  status_reg_rd_i,
        output quarter_frame_o,
        output half_frame_o,
        output frame_irq_o
    );
endinterface

// File: rtl/cpu_rp2a03_apu_frame_counter.sv
// RP2A03 APU frame counter: 4-step / 5-step sequencer producing quarter- and
// half-frame clock pulses and the frame IRQ flag, with the $4017 reset delay.
module cpu_rp2a03_apu_frame_counter (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    cpu_rp2a03_apu_frame_counter_if.slave       fc_if
);
    localparam logic [15:0] CNT_Q1     = 16'd7457;
    localparam logic [15:0] CNT_H1     = 16'd14913;
    localparam logic [15:0] CNT_Q3     = 16'd22371;
    localparam logic [15:0] CNT_IRQ_LO = 16'd29828;
    localparam logic [15:0] CNT_4_H2   = 16'd29829;
    localparam logic [15:0] CNT_4_END  = 16'd29830;
    localparam logic [15:0] CNT_5_H2   = 16'd37281;
    localparam logic [15:0] CNT_5_END  = 16'd37282;

    logic [15:0] cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic        inhibit_q, inhibit_d;
    logic        irq_q, irq_d;
    logic        delay_armed_q, delay_armed_d;
    logic [1:0]  delay_q, delay_d;
    logic        quarter_q, quarter_d;
    logic        half_q, half_d;

    logic strobe, wr, rd;
    logic q_evt, h_evt, irq_evt, seq_end, expire, inhibit_eff, irq_set;
    logic wr_data_unused;

    assign strobe = fc_if.cpu_cycle_i;
    assign wr     = fc_if.frame_counter_reg_wr_i;
    assign rd     = fc_if.status_reg_rd_i;
    assign wr_data_unused = ^fc_if.frame_counter_wr_data_i[5:0];

    // Event decode from the current count; the ">=" end test also pulls the
    // count back in range after a 5-step -> 4-step mode switch.
    assign q_evt   = (cnt_q == CNT_Q1) || (cnt_q == CNT_Q3);
    assign h_evt   = (cnt_q == CNT_H1) || (!mode_q && cnt_q == CNT_4_H2) ||
                     (mode_q && cnt_q == CNT_5_H2);
    assign irq_evt = !mode_q && (cnt_q >= CNT_IRQ_LO) && (cnt_q <= CNT_4_END);
    assign seq_end = mode_q ? (cnt_q >= CNT_5_END) : (cnt_q >= CNT_4_END);

    // A write on the expiring strobe restarts the delay instead of expiring it.
    assign expire      = strobe && delay_armed_q && (delay_q == 2'd1) && !wr;
    assign inhibit_eff = wr ? fc_if.frame_counter_wr_data_i[6] : inhibit_q;

    always_comb begin
        cnt_d         = cnt_q;
        mode_d        = mode_q;
        inhibit_d     = inhibit_q;
        irq_d         = irq_q;
        delay_armed_d = delay_armed_q;
        delay_d       = delay_q;
        quarter_d     = 1'b0;
        half_d        = 1'b0;
        irq_set       = 1'b0;

        if (strobe) begin
            if (expire) begin
                cnt_d         = 16'd0;
                delay_armed_d = 1'b0;
                quarter_d     = mode_q;
                half_d        = mode_q;
            end else begin
                cnt_d     = seq_end ? 16'd0 : cnt_q + 16'd1;
                quarter_d = q_evt || h_evt;
                half_d    = h_evt;
                irq_set   = irq_evt;
                if (delay_armed_q) begin
                    delay_d = delay_q - 2'd1;
                end
            end
        end

        if (wr && fc_if.frame_counter_wr_data_i[6]) begin
            irq_d = 1'b0;
        end else if (irq_set && !inhibit_eff) begin
            irq_d = 1'b1;
        end else if (rd) begin
            irq_d = 1'b0;
        end

        if (wr) begin
            mode_d        = fc_if.frame_counter_wr_data_i[7];
            inhibit_d     = fc_if.frame_counter_wr_data_i[6];
            delay_armed_d = 1'b1;
            delay_d       = 2'd3;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q         <= 16'd0;
            mode_q        <= 1'b0;
            inhibit_q     <= 1'b0;
            irq_q         <= 1'b0;
            delay_armed_q <= 1'b0;
            delay_q       <= 2'd0;
            quarter_q     <= 1'b0;
            half_q        <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            inhibit_q     <= inhibit_d;
            irq_q         <= irq_d;
            delay_armed_q <= delay_armed_d;
            delay_q       <= delay_d;
            quarter_q     <= quarter_d;
            half_q        <= half_d;
        end
    end

    assign fc_if.quarter_frame_o = quarter_q;
    assign fc_if.half_frame_o    = half_q;
    assign fc_if.frame_irq_o     = irq_q;
endmodule

// File: doc/cpu_rp2a03_apu_frame_counter.md
CPU_RP2A03_APU_FRAME_COUNTER -- requirements
Module: cpu_RP2A03_apu_frame_counter

Interface
REQ-001 SHALL have port clk_i, input, 1: system clock; the only clock.
REQ-002 SHALL have port rst_n_i, input, 1: reset, synchronous and active-low.
REQ-003 SHALL have port cpu_cycle_i, input, 1: one-clk enable strobe, one per CPU cycle.
REQ-004 SHALL have port frame_counter_reg_wr_i, input, 1: one-clk write strobe for the $4017 register.
REQ-005 SHALL have port frame_counter_wr_data_i, input, 8: write data; bit7 = mode (0 = 4-step, 1 = 5-step); bit6 = IRQ inhibit.
REQ-006 SHALL have port status_reg_rd_i, input, 1: one-clk strobe for a $4015 read; clears the frame IRQ flag.
REQ-007 SHALL have port quarter_frame_o, output, 1: one-clk pulse that clocks envelopes and linear counter.
REQ-008 SHALL have port half_frame_o, output, 1: one-clk pulse that clocks length counters and sweeps.
REQ-009 SHALL have port frame_irq_o, output, 1: frame IRQ flag, level.

Function
REQ-010 SHALL hold a 16-bit cycle counter, cnt, that increments by 1 on each clk where cpu_cycle_i = 1 and holds otherwise.
REQ-011 SHALL, in 4-step mode, act on the cpu_cycle_i strobe at these cnt values: 7457 Q; 14913 Q+H; 22371 Q; 29828 IRQ-set; 29829 Q+H+IRQ-set; 29830 IRQ-set with the next cnt = 0.
REQ-012 SHALL, in 5-step mode, act on the cpu_cycle_i strobe at these cnt values: 7457 Q; 14913 Q+H; 22371 Q; 29829 no event; 37281 Q+H; 37282 with the next cnt = 0; IRQ is never set.
REQ-013 SHALL register Q/H events so quarter_frame_o/half_frame_o assert for exactly one clk, in the clk immediately after the matching cpu_cycle_i strobe; an H event always asserts both outputs.
REQ-014 SHALL set the IRQ flag on an IRQ-set event only if inhibit = 0; frame_irq_o is the registered flag, visible one clk after the event.
REQ-015 SHALL clear the IRQ flag one clk after status_reg_rd_i; if an IRQ-set event and status_reg_rd_i coincide, set SHALL win.
REQ-016 SHALL latch mode and inhibit on frame_counter_reg_wr_i in the same clk; inhibit = 1 SHALL clear the IRQ flag in that same edge and SHALL override a coincident IRQ-set.
REQ-017 SHALL arm a counter-reset delay on a write: a 2-bit delay counter loaded with 3; it decrements on each cpu_cycle_i strobe; when it reaches 0, cnt := 0 at that strobe and the delay disarms.
REQ-018 SHALL, when the reset delay expires with mode = 5-step, emit Q+H pulses in the next clk (REQ-013 timing); for 4-step, no pulse.
REQ-019 SHALL ignore scheduled Q/H/IRQ events at the strobe where the delay expires; cnt reset takes priority over the wrap.
REQ-020 SHALL restart the delay from 3 on a write while the delay is armed, using the new mode/inhibit values.
REQ-021 SHALL NOT advance cnt, the delay, or any event on a clk without cpu_cycle_i; writes and reads SHALL still take effect.
REQ-022 SHALL produce no pulses or IRQ from cnt values outside the listed ones; cnt SHALL never exceed 37282.

Reset
REQ-023 SHALL, on clk with rst_n_i = 0, clear cnt = 0, mode = 0, inhibit = 0, IRQ flag = 0, delay disarmed, and quarter_frame_o = half_frame_o = frame_irq_o = 0.
REQ-024 SHALL let reset win over any coincident strobe, write, or read; a reset asserted mid-sequence or mid-delay SHALL discard all pending state.
REQ-025 SHALL begin counting with the first cpu_cycle_i after rst_n_i returns to 1, in 4-step mode with IRQ enabled.

Verification
REQ-026 SHALL cover: reset, then cpu_cycle_i every clk -> Q pulses after strobes at cnt 7457/14913/22371/29829; H pulses at 14913/29829; frame_irq_o rises after 29828; sequence repeats from 0.
REQ-027 SHALL cover: write 8'h80 -> after 3 strobes Q+H pulse; then Q at 7457/14913/22371/37281, H at 14913/37281; frame_irq_o stays 0 for two full sequences.
REQ-028 SHALL cover: IRQ pending, then write 8'h40 -> frame_irq_o = 0 after that clk; no IRQ through 29830; then write 8'h00 -> IRQ returns next sequence.
REQ-029 SHALL cover: status_reg_rd_i coincident with the 29829 strobe -> frame_irq_o stays 1; a read at 29831 -> frame_irq_o = 0.
REQ-030 SHALL cover: write at delay count 1 -> delay restarts (cnt reset 3 strobes after second write); strobes gapped (cpu_cycle_i 1 in 3 clk) -> identical event cnt values, pulses still 1 clk wide.
REQ-031 SHALL cover: rst_n_i = 0 at cnt 20000 in 5-step with delay armed -> all outputs 0 next clk; after release, 4-step timing of REQ-026.
